// File: rtl/sp_row_feeder_if.sv
// sp_row_feeder_if: 4-lane sparse nonzero beat stream, valid/ready handshake.
interface sp_row_feeder_if #(parameter int CW = 8);
  logic [4*CW-1:0] Scol_index;
  logic [31:0] S_val_i0, S_val_i1, S_val_i2, S_val_i3;
  logic [31:0] S_val_r0, S_val_r1, S_val_r2, S_val_r3;
  logic [CW-1:0] S_row_o;
  logic S_last_o, S_vld_o, S_rdy_o;
  modport master (
    output Scol_index, S_val_i0, S_val_i1, S_val_i2, S_val_i3,
    output S_val_r0, S_val_r1, S_val_r2, S_val_r3, S_row_o, S_last_o, S_vld_o,
    input S_rdy_o
  );
  modport slave (
    input Scol_index, S_val_i0, S_val_i1, S_val_i2, S_val_i3,
    input S_val_r0, S_val_r1, S_val_r2, S_val_r3, S_row_o, S_last_o, S_vld_o,
    output S_rdy_o
  );
endinterface

// File: rtl/sp_row_feeder.sv
// sp_row_feeder: walks a CSR complex sparse matrix and streams 4-lane nonzero beats.
// Define SP_FEEDER_SKIP_EMPTY_EN to drop empty rows instead of sending a zero beat.
module sp_row_feeder #(
  parameter int MAT_RANK = 256,
  parameter int NNZ_MAX = 4096,
  localparam int CW = $clog2(MAT_RANK),
  localparam int PW = $clog2(NNZ_MAX + 1),
  localparam int AW = $clog2(NNZ_MAX),
  localparam int RW = $clog2(MAT_RANK + 1)
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  output logic busy,
  output logic done,
  output logic ptr_en,
  output logic [RW-1:0] ptr_addr,
  input  logic [PW-1:0] ptr_dout,
  output logic nz_en,
  output logic [AW-1:0] nz_addr,
  input  logic [CW+63:0] nz_dout,
  sp_row_feeder_if.master s
);
  localparam logic [2:0] IDLE = 3'd0, P0 = 3'd1, PN = 3'd2, FILL = 3'd3, SEND = 3'd4;
  localparam logic [RW-1:0] LAST_ROW = RW'(MAT_RANK - 1);
  logic [2:0] state_q;
  logic ph_q, wr_q, vld_q, last_q, done_q;
  logic [1:0] cnt_q, wl_q;
  logic [RW-1:0] r_q, r_d;
  logic [PW-1:0] beg_q, end_q, beg_d;
  logic [3:0][CW-1:0] col_q;
  logic [3:0][31:0] vr_q, vi_q;
  logic final_row, empty, fill_end, clr;
  assign beg_d = beg_q + 1'b1;
  assign r_d = r_q + RW'(r_q != RW'(MAT_RANK));
  assign final_row = r_q == LAST_ROW;
  assign empty = ptr_dout <= beg_q;
  assign fill_end = cnt_q == 2'd3 || beg_d == end_q;
  assign clr = (state_q == PN && ph_q) || (state_q == SEND && vld_q && s.S_rdy_o && !last_q);
  assign busy = state_q != IDLE;
  assign done = done_q;
  // PN spends one cycle issuing ptr[r+1] and one cycle capturing it
  assign ptr_en = state_q == P0 || (state_q == PN && !ph_q);
  assign ptr_addr = (state_q == PN && !ph_q) ? r_q + 1'b1 : '0;
  assign nz_en = state_q == FILL;
  assign nz_addr = nz_en ? beg_q[AW-1:0] : '0;
  assign s.Scol_index = col_q;
  assign s.S_val_r0 = vr_q[0];
  assign s.S_val_r1 = vr_q[1];
  assign s.S_val_r2 = vr_q[2];
  assign s.S_val_r3 = vr_q[3];
  assign s.S_val_i0 = vi_q[0];
  assign s.S_val_i1 = vi_q[1];
  assign s.S_val_i2 = vi_q[2];
  assign s.S_val_i3 = vi_q[3];
  assign s.S_row_o = r_q[CW-1:0];
  assign s.S_last_o = last_q;
  assign s.S_vld_o = vld_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      ph_q <= 1'b0;
      wr_q <= 1'b0;
      vld_q <= 1'b0;
      last_q <= 1'b0;
      done_q <= 1'b0;
      cnt_q <= '0;
      wl_q <= '0;
      r_q <= '0;
      beg_q <= '0;
      end_q <= '0;
      col_q <= '0;
      vr_q <= '0;
      vi_q <= '0;
    end else begin
      done_q <= 1'b0;
      wr_q <= 1'b0;
      // read data lands one cycle after the FILL address that requested it
      if (clr) begin
        col_q <= '0;
        vr_q <= '0;
        vi_q <= '0;
      end else if (wr_q) begin
        col_q[wl_q] <= nz_dout[CW+63:64];
        vr_q[wl_q] <= nz_dout[63:32];
        vi_q[wl_q] <= nz_dout[31:0];
      end
      case (state_q)
        IDLE: if (start && !done_q) begin
          state_q <= P0;
          r_q <= '0;
        end
        P0: begin
          state_q <= PN;
          ph_q <= 1'b0;
        end
        PN: if (!ph_q) begin
          ph_q <= 1'b1;
          if (r_q == '0) beg_q <= ptr_dout;
        end else begin
          ph_q <= 1'b0;
          end_q <= ptr_dout;
          if (!empty) begin
            state_q <= FILL;
            cnt_q <= '0;
          end
`ifdef SP_FEEDER_SKIP_EMPTY_EN
          else if (final_row) begin
            state_q <= IDLE;
            done_q <= 1'b1;
          end else begin
            r_q <= r_d;
            beg_q <= ptr_dout;
          end
`else
          else begin
            state_q <= SEND;
            last_q <= 1'b1;
          end
`endif
        end
        FILL: begin
          beg_q <= beg_d;
          cnt_q <= cnt_q + 1'b1;
          wl_q <= cnt_q;
          wr_q <= 1'b1;
          last_q <= beg_d == end_q;
          if (fill_end) state_q <= SEND;
        end
        SEND: if (!vld_q) vld_q <= 1'b1;
        else if (s.S_rdy_o) begin
          vld_q <= 1'b0;
          if (!last_q) begin
            state_q <= FILL;
            cnt_q <= '0;
          end else if (final_row) begin
            state_q <= IDLE;
            done_q <= 1'b1;
          end else begin
            state_q <= PN;
            r_q <= r_d;
            beg_q <= end_q;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_sp_row_feeder.sv
// tb_sp_row_feeder: directed CSR passes over an 8x8 matrix, beats checked against tables.
`timescale 1ns/1ps
module tb_sp_row_feeder;
  localparam int MR = 8, NZ = 64, CW = 3, PW = 7, AW = 6, RW = 4;
  typedef struct { int row; bit last; int n; int base; } exp_t;
  typedef struct packed {
    logic [CW-1:0] row;
    logic last;
    logic [4*CW-1:0] col;
    logic [127:0] vr;
    logic [127:0] vi;
  } beat_t;
  logic clk = 1'b0, rst = 1'b1, start = 1'b0;
  logic busy, done, ptr_en, nz_en;
  logic [RW-1:0] ptr_addr;
  logic [PW-1:0] ptr_dout;
  logic [AW-1:0] nz_addr;
  logic [CW+63:0] nz_dout;
  logic [PW-1:0] ptr_mem [16];
  logic [CW-1:0] col_mem [64];
  sp_row_feeder_if #(.CW(CW)) s_if ();
  sp_row_feeder #(.MAT_RANK(MR), .NNZ_MAX(NZ)) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
    .ptr_en(ptr_en), .ptr_addr(ptr_addr), .ptr_dout(ptr_dout),
    .nz_en(nz_en), .nz_addr(nz_addr), .nz_dout(nz_dout), .s(s_if)
  );
  always #5 clk = ~clk;
  always @(posedge clk) begin
    if (ptr_en) ptr_dout <= ptr_mem[ptr_addr];
    if (nz_en) nz_dout <= {col_mem[nz_addr], 32'h1000_0000 + 32'(nz_addr), 32'h2000_0000 + 32'(nz_addr)};
  end
  int rdy_mode = 0;
  always @(posedge clk) begin
    #1;
    s_if.S_rdy_o = rdy_mode == 0 ? 1'b1 : ($urandom_range(99) < 30);
  end
  int checks = 0, fails = 0, ndone = 0, lowc = 0;
  bit stall = 0, fin_hs = 0;
  beat_t prev, cur;
  beat_t beats [$];
  int gaps [$];
  exp_t exq [$];
  task automatic chk(input string nm, input logic [299:0] act, input logic [299:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  function automatic beat_t snap();
    return {s_if.S_row_o, s_if.S_last_o, s_if.Scol_index,
            s_if.S_val_r3, s_if.S_val_r2, s_if.S_val_r1, s_if.S_val_r0,
            s_if.S_val_i3, s_if.S_val_i2, s_if.S_val_i1, s_if.S_val_i0};
  endfunction
  // monitor: beat capture, hold-while-stalled, done timing, vld-low gap count
  always @(negedge clk) begin
    cur = snap();
    if (stall && s_if.S_vld_o) chk("hold_stable", cur, prev);
    stall = s_if.S_vld_o && !s_if.S_rdy_o;
    prev = cur;
    if (done) begin
      ndone++;
      chk("done_after_final_hs", fin_hs, 1);
    end
    fin_hs = s_if.S_vld_o && s_if.S_rdy_o && s_if.S_last_o && s_if.S_row_o == CW'(MR - 1);
    if (s_if.S_vld_o && s_if.S_rdy_o) begin
      beats.push_back(cur);
      gaps.push_back(lowc);
      lowc = 0;
    end else if (busy && !s_if.S_vld_o) lowc++;
  end
  function automatic void add(int row, bit last, int n, int base);
    exq.push_back('{row, last, n, base});
  endfunction
  task automatic load_identity();
    for (int i = 0; i <= MR; i++) ptr_mem[i] = PW'(i);
    for (int i = 0; i < NZ; i++) col_mem[i] = CW'(i);
    exq.delete();
    for (int r = 0; r < MR; r++) add(r, 1, 1, r);
  endtask
  task automatic load_mixed();
    int p [9];
    p = '{0, 6, 7, 7, 11, 16, 17, 18, 19};
    for (int i = 0; i <= MR; i++) ptr_mem[i] = PW'(p[i]);
    for (int i = 0; i < NZ; i++) col_mem[i] = CW'(i < 6 ? i + 1 : i * 3);
    exq.delete();
    add(0, 0, 4, 0);
    add(0, 1, 2, 4);
    add(1, 1, 1, 6);
`ifndef SP_FEEDER_SKIP_EMPTY_EN
    add(2, 1, 0, 0);
`endif
    add(3, 1, 4, 7);
    add(4, 0, 4, 11);
    add(4, 1, 1, 15);
    add(5, 1, 1, 16);
    add(6, 1, 1, 17);
    add(7, 1, 1, 18);
  endtask
  task automatic compare(input string tag);
    chk({tag, "_nbeats"}, beats.size(), exq.size());
    for (int j = 0; j < exq.size() && j < beats.size(); j++) begin
      exp_t e;
      logic [4*CW-1:0] ec;
      logic [127:0] er, ei;
      int eg;
      e = exq[j];
      ec = '0;
      er = '0;
      ei = '0;
      for (int l = 0; l < e.n; l++) begin
        ec[l*CW +: CW] = col_mem[e.base + l];
        er[l*32 +: 32] = 32'h1000_0000 + e.base + l;
        ei[l*32 +: 32] = 32'h2000_0000 + e.base + l;
      end
      eg = j == 0 ? e.n + 4 + 2 * e.row :
           exq[j-1].row == e.row ? e.n + 1 : e.n + 3 + 2 * (e.row - exq[j-1].row - 1);
      chk($sformatf("%s_b%0d_row", tag, j), beats[j].row, e.row);
      chk($sformatf("%s_b%0d_last", tag, j), beats[j].last, e.last);
      chk($sformatf("%s_b%0d_col", tag, j), beats[j].col, ec);
      chk($sformatf("%s_b%0d_vr", tag, j), beats[j].vr, er);
      chk($sformatf("%s_b%0d_vi", tag, j), beats[j].vi, ei);
      chk($sformatf("%s_b%0d_gap", tag, j), gaps[j], eg);
    end
  endtask
  task automatic chk_zero(input string tag);
    chk({tag, "_ctl"}, {busy, done, ptr_en, nz_en, s_if.S_vld_o, s_if.S_last_o}, 0);
    chk({tag, "_beat"}, snap(), 0);
  endtask
  task automatic run_pass(input string tag, input int mode, input bit poke);
    rdy_mode = mode;
    @(posedge clk);
    #1;
    beats.delete();
    gaps.delete();
    lowc = 0;
    ndone = 0;
    stall = 0;
    fin_hs = 0;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 3000 && !done; i++) begin
      @(negedge clk);
      start = poke && i == 15;
    end
    chk({tag, "_done_seen"}, done, 1);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (30) @(negedge clk);
    chk({tag, "_idle_after"}, busy, 0);
    chk({tag, "_ndone"}, ndone, 1);
    compare(tag);
  endtask
  initial begin
    repeat (3) @(negedge clk);
    chk_zero("reset");
    rst = 1'b0;
    load_identity();
    run_pass("ident", 0, 0);
    load_mixed();
    run_pass("mixed", 0, 1);
    run_pass("mixed_rnd", 1, 1);
    rdy_mode = 0;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 2000 && !(nz_en && s_if.S_row_o == 3'd5); i++) @(negedge clk);
    chk("reach_row5_fill", {nz_en, s_if.S_row_o}, {1'b1, 3'd5});
    rst = 1'b1;
    @(negedge clk);
    chk_zero("mid_rst");
    rst = 1'b0;
    run_pass("replay", 0, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule

// File: doc/sp_row_feeder.md
# sp_row_feeder

Sparse-matrix row streamer: walks a CSR-stored complex sparse matrix and drives the 4-lane nonzero stream (`Scol_index`, `S_val_*`, `S_vld_o`/`S_rdy_o`) that the sparse matrix-vector multiplier consumes. It is the transmitter end of that interface. It reads row pointers and nonzero entries from two external 1-cycle-latency RAMs, packs up to 4 nonzeros per beat and pads unused lanes with zero. It sits between the matrix storage RAMs and `mat_multi`.

## Interface
- `MAT_RANK`, 256, matrix rows/columns; `CW = $clog2(MAT_RANK)`
- `NNZ_MAX`, 4096, nonzero RAM depth; `PW = $clog2(NNZ_MAX+1)`, `AW = $clog2(NNZ_MAX)`

Ports:
- `clk`  in  1  single clock
- `rst`  in  1  synchronous, active-high reset
- `start`  in  1  pulse; begins a full matrix pass
- `busy`  out  1  high from start acceptance until `done`
- `done`  out  1  1-cycle pulse after the last beat handshake
- `ptr_en`  out  1  row-pointer RAM read enable
- `ptr_addr`  out  `$clog2(MAT_RANK+1)`  row-pointer address
- `ptr_dout`  in  PW  row-pointer data, valid the cycle after `ptr_en`
- `nz_en`  out  1  nonzero RAM read enable
- `nz_addr`  out  AW  nonzero address
- `nz_dout`  in  CW+64  `{col, val_r[31:0], val_i[31:0]}`, valid the cycle after `nz_en`
- `Scol_index`  out  4*CW  lane n at bits [n*CW +: CW]
- `S_val_i0..3`, `S_val_r0..3`  out  32 each  lane imaginary/real parts
- `S_row_o`  out  CW  row index of current beat
- `S_last_o`  out  1  final beat of the row
- `S_vld_o`  out  1  beat valid
- `S_rdy_o`  in  1  consumer ready

## Operation
- FSM states: IDLE, P0, PN, FILL, SEND.
- IDLE: `start` accepted, so `busy`=1, read `ptr[0]`, go to P0. `start` is ignored while `busy`.
- P0: read `ptr[r+1]`, capture `ptr[0]` as `beg`, go to PN.
- PN: capture `end`. If `end <= beg` the row is empty: load an all-zero beat with `S_last_o`=1 and go to SEND. Otherwise go to FILL.
- FILL: issue up to `min(4, end-beg)` consecutive `nz` reads from `beg`. Each returned word lands in the next lane. Remaining lanes are col=0, val=0. `beg` advances by the count. Go to SEND.
  - `S_last_o` = (`beg` == `end` after advance).
- SEND: hold all beat outputs stable while `S_vld_o`=1. On `S_vld_o & S_rdy_o`:
  - not last: go to FILL;
  - last, more rows: `r`++, `beg`=`end`, read `ptr[r+1]`, go to PN;
  - last, row MAT_RANK-1: `done` pulse, `busy`=0, go to IDLE.
- Row counter `r` is CW+1 bits wide and saturates at MAT_RANK. Address arithmetic is unsigned PW bits. `nz_addr` = `beg`[AW-1:0].
- Malformed pointer (`end < beg`) is treated as an empty row. No error flag.

## Timing
- Reset: FSM=IDLE. All outputs 0: `busy`, `done`, `S_vld_o`, `ptr_en`, `nz_en`, `Scol_index`, `S_val_*`, `S_row_o`, `S_last_o`.
- Reset mid-pass aborts the pass immediately. No partial `done` is produced.
- `start` seen at edge k:
  - `ptr_en`/addr 0 at k+1; addr 1 at k+2; `end` captured at k+3;
  - nz reads at k+4..k+4+n-1; `S_vld_o` rises at k+5+n (n = lanes read, 1..4).
- Next beat of same row: `S_vld_o` deasserts for n+1 cycles after handshake. Next row adds 2 cycles for the pointer read.
- `S_vld_o`, once high, stays high with stable data until `S_rdy_o`. It never depends combinationally on `S_rdy_o`.
- `done` asserts the cycle after the final handshake. `start` in that same cycle is ignored.

## Configuration
- `SP_FEEDER_SKIP_EMPTY_EN`
  - Defined: empty rows emit no beat. PN advances directly to the next row's pointer read, or to `done` if it was the final row.
  - Undefined: each empty row emits one zero beat with `S_last_o`=1 and the correct `S_row_o`.

## Test plan
- Identity 4x4 (MAT_RANK=4), `ptr`={0,1,2,3,4}, `S_rdy_o`=1 -> 4 beats, one per row, each with lane0 col=r and lanes1-3 zero, `S_last_o`=1; `done` 1 cycle after 4th handshake.
- Row with 6 nonzeros at cols 1..6 -> 2 beats: first has cols 1-4 and `S_last_o`=0; second has cols 5,6 plus two zero lanes and `S_last_o`=1; first `S_vld_o` exactly k+9 after start.
- Empty row 2 (`ptr[2]==ptr[3]`) -> without macro: zero beat with `S_row_o`=2; with `SP_FEEDER_SKIP_EMPTY_EN`: no beat for row 2, `S_row_o` jumps 1 to 3.
- `S_rdy_o` randomly toggled, 30% duty -> beat outputs bit-stable while vld & !rdy; beat sequence identical to the rdy=1 run.
- `rst` asserted mid-FILL of row 5 -> next cycle all outputs 0, FSM idle; a new `start` replays from row 0.
- `start` pulsed while `busy` and in the `done` cycle -> ignored, exactly one `done` per accepted start.
